// File: rtl/bus_wait_gen.sv
// bus_wait_gen -- wait-state generator for an 8088 core bus.
//
// Tracks each bus cycle from ALE through the strobe phase, classifies it
// (memory/I-O read/write, interrupt acknowledge), and holds the core's READY
// low for a per-type number of wait cycles, further stretched by EXT_RDY.
//
// Optional feature (macro BUS_TIMEOUT_EN): an 8-bit WAIT-cycle watchdog forces
// completion after TIMEOUT_CYCLES, pulses TIMEOUT and records TIMEOUT_ADDR.
// Without the macro, TIMEOUT/TIMEOUT_ADDR are tied to 0.
//
// Ports:
//   CORE_CLK      in   sole clock, rising edge
//   RESET_n       in   asynchronous active-low reset
//   ALE           in   address latch enable
//   RD_n/WR_n/INTA_n in active-low bus strobes
//   IOM           in   1 = I/O cycle, 0 = memory cycle
//   ADDR[19:0]    in   bus address, valid while ALE=1
//   EXT_RDY       in   device ready; 0 extends the cycle
//   READY         out  registered READY to the core
//   BUS_CYCLE[2:0] out 0 idle,1 mem rd,2 mem wr,3 io rd,4 io wr,5 inta
//   CYC_ADDR[19:0] out address latched for the current cycle
//   TIMEOUT       out  one-cycle pulse on forced completion
//   TIMEOUT_ADDR[19:0] out CYC_ADDR of the most recent timed-out cycle
module bus_wait_gen #(
  parameter int unsigned MEM_WAIT       = 0,
  parameter int unsigned IO_WAIT        = 1,
  parameter int unsigned INTA_WAIT      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CORE_CLK,
  input  logic        RESET_n,
  input  logic        ALE,
  input  logic        RD_n,
  input  logic        WR_n,
  input  logic        INTA_n,
  input  logic        IOM,
  input  logic [19:0] ADDR,
  input  logic        EXT_RDY,
  output logic        READY,
  output logic [2:0]  BUS_CYCLE,
  output logic [19:0] CYC_ADDR,
  output logic        TIMEOUT,
  output logic [19:0] TIMEOUT_ADDR
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    CYC_IDLE   = 3'd0,
    CYC_MEM_RD = 3'd1,
    CYC_MEM_WR = 3'd2,
    CYC_IO_RD  = 3'd3,
    CYC_IO_WR  = 3'd4,
    CYC_INTA   = 3'd5
  } cyc_t;

  localparam logic [3:0] MEM_W  = 4'(MEM_WAIT);
  localparam logic [3:0] IO_W   = 4'(IO_WAIT);
  localparam logic [3:0] INTA_W = 4'(INTA_WAIT);

  if (MEM_WAIT > 15 || IO_WAIT > 15 || INTA_WAIT > 15 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("bus_wait_gen: wait counts must be 0-15 and TIMEOUT_CYCLES 1-255");
  end

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  cyc_t        cyc_q, cyc_d;
  logic [19:0] cyc_addr_q, cyc_addr_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        strobe_any;
  logic        strobes_idle;
  cyc_t        cyc_type;
  logic [3:0]  load_cnt;
  logic [3:0]  cnt_dec;
  logic        wait_done;
  logic        to_hit;

  assign strobe_any   = !RD_n || !WR_n || !INTA_n;
  assign strobes_idle = RD_n && WR_n && INTA_n;

  // Cycle classification; INTA beats WR beats RD when several strobes are low.
  always_comb begin
    cyc_type = CYC_MEM_RD;
    load_cnt = MEM_W;
    if (!INTA_n) begin
      cyc_type = CYC_INTA;
      load_cnt = INTA_W;
    end else if (!WR_n) begin
      cyc_type = IOM ? CYC_IO_WR : CYC_MEM_WR;
      load_cnt = IOM ? IO_W : MEM_W;
    end else begin
      cyc_type = IOM ? CYC_IO_RD : CYC_MEM_RD;
      load_cnt = IOM ? IO_W : MEM_W;
    end
  end

  // Completion is judged on the post-decrement count so that a loaded count
  // of W yields exactly W low READY cycles when EXT_RDY is already high.
  assign cnt_dec   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
  assign wait_done = (cnt_dec == 4'd0) && EXT_RDY;

  // State and output registers
  always_ff @(posedge CORE_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      cyc_q      <= CYC_IDLE;
      cyc_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      cyc_q      <= cyc_d;
      cyc_addr_q <= cyc_addr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic; ALE in any state restarts at ADDR.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ALE) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (ALE)             state_d = ST_ADDR;
        else if (strobe_any) state_d = (load_cnt == 4'd0) ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        if (ALE)                      state_d = ST_ADDR;
        else if (strobes_idle)        state_d = ST_IDLE;
        else if (wait_done || to_hit) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (ALE)               state_d = ST_ADDR;
        else if (strobes_idle) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next register values derived from the transition being taken.
  always_comb begin
    ready_d    = (state_d != ST_WAIT);
    cyc_d      = cyc_q;
    cyc_addr_d = cyc_addr_q;
    cnt_d      = cnt_q;

    if (ALE) cyc_addr_d = ADDR;

    if (state_d == ST_IDLE || state_d == ST_ADDR) begin
      cyc_d = CYC_IDLE;
    end else if (state_q == ST_ADDR) begin
      cyc_d = cyc_type;
    end

    if (state_q == ST_ADDR && state_d != ST_ADDR) begin
      cnt_d = load_cnt;
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_dec;
    end
  end

  assign READY     = ready_q;
  assign BUS_CYCLE = cyc_q;
  assign CYC_ADDR  = cyc_addr_q;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        to_fire;
  logic        timeout_q;
  logic [19:0] to_addr_q;

  // to_cnt_q counts completed WAIT cycles; the edge that would make it reach
  // the limit is the one that forces completion, so it never wraps.
  assign to_hit  = (state_q == ST_WAIT) && ((to_cnt_q + 8'd1) == TO_LIMIT);
  // A forced completion is a WAIT->DONE move the normal condition did not cause.
  assign to_fire = (state_q == ST_WAIT) && (state_d == ST_DONE) && !wait_done;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q != ST_WAIT && state_d == ST_WAIT) begin
      to_cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      to_cnt_d = to_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CORE_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
      to_addr_q <= '0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= to_fire;
      if (to_fire) to_addr_q <= cyc_addr_q;
    end
  end

  assign TIMEOUT      = timeout_q;
  assign TIMEOUT_ADDR = to_addr_q;
`else
  assign to_hit       = 1'b0;
  assign TIMEOUT      = 1'b0;
  assign TIMEOUT_ADDR = '0;
`endif

endmodule

// File: tb/tb_bus_wait_gen.sv
// Directed testbench for bus_wait_gen with a queue-based scoreboard.
// Stimulus pushes the expected post-edge outputs; a monitor on the falling
// edge pops and compares them.
module tb_bus_wait_gen;

  logic        clk;
  logic        rst_n;
  logic        ale;
  logic        rd_n;
  logic        wr_n;
  logic        inta_n;
  logic        iom;
  logic [19:0] addr;
  logic        ext_rdy;
  logic        ready;
  logic [2:0]  bus_cycle;
  logic [19:0] cyc_addr;
  logic        timeout;
  logic [19:0] timeout_addr;

  bus_wait_gen #(
    .MEM_WAIT      (0),
    .IO_WAIT       (3),
    .INTA_WAIT     (1),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CORE_CLK    (clk),
    .RESET_n     (rst_n),
    .ALE         (ale),
    .RD_n        (rd_n),
    .WR_n        (wr_n),
    .INTA_n      (inta_n),
    .IOM         (iom),
    .ADDR        (addr),
    .EXT_RDY     (ext_rdy),
    .READY       (ready),
    .BUS_CYCLE   (bus_cycle),
    .CYC_ADDR    (cyc_addr),
    .TIMEOUT     (timeout),
    .TIMEOUT_ADDR(timeout_addr)
  );

  typedef struct {
    string       name;
    logic        rdy;
    logic [2:0]  bc;
    logic [19:0] ca;
    logic        to;
    logic [19:0] toa;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [19:0] exp_toaddr = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected record per falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (ready !== e.rdy || bus_cycle !== e.bc || cyc_addr !== e.ca ||
          timeout !== e.to || timeout_addr !== e.toa) begin
        failures++;
        $display("FAIL %s: got ready=%b bus_cycle=%0d cyc_addr=%05h timeout=%b timeout_addr=%05h, want ready=%b bus_cycle=%0d cyc_addr=%05h timeout=%b timeout_addr=%05h",
                 e.name, ready, bus_cycle, cyc_addr, timeout, timeout_addr,
                 e.rdy, e.bc, e.ca, e.to, e.toa);
      end
    end
  end

  task automatic drv(input logic a_ale, input logic a_rd, input logic a_wr,
                     input logic a_inta, input logic a_iom,
                     input logic [19:0] a_addr, input logic a_ext);
    ale     = a_ale;
    rd_n    = a_rd;
    wr_n    = a_wr;
    inta_n  = a_inta;
    iom     = a_iom;
    addr    = a_addr;
    ext_rdy = a_ext;
  endtask

  task automatic step(input string name, input logic rdy, input logic [2:0] bc,
                      input logic [19:0] ca, input logic to);
    exp_t e;
    e.name = name;
    e.rdy  = rdy;
    e.bc   = bc;
    e.ca   = ca;
    e.to   = to;
    e.toa  = exp_toaddr;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drv(0, 1, 1, 1, 0, 20'h0, 1);
    step("reset", 1, 0, 20'h0, 0);
    rst_n = 1'b1;
    step("idle_after_reset", 1, 0, 20'h0, 0);

    // Memory read, zero wait states
    drv(1, 1, 1, 1, 0, 20'hF0000, 1); step("memrd_ale",  1, 0, 20'hF0000, 0);
    drv(0, 0, 1, 1, 0, 20'h0, 1);     step("memrd_strb", 1, 1, 20'hF0000, 0);
                                      step("memrd_hold", 1, 1, 20'hF0000, 0);
    drv(0, 1, 1, 1, 0, 20'h0, 1);     step("memrd_end",  1, 0, 20'hF0000, 0);

    // I/O write, three wait states
    drv(1, 1, 1, 1, 1, 20'h00060, 1); step("iowr_ale", 1, 0, 20'h00060, 0);
    drv(0, 1, 0, 1, 1, 20'h0, 1);     step("iowr_w1",  0, 4, 20'h00060, 0);
                                      step("iowr_w2",  0, 4, 20'h00060, 0);
                                      step("iowr_w3",  0, 4, 20'h00060, 0);
                                      step("iowr_done",1, 4, 20'h00060, 0);
    drv(0, 1, 1, 1, 1, 20'h0, 1);     step("iowr_end", 1, 0, 20'h00060, 0);

    // INTA, one wait state, EXT_RDY low for five sampled edges
    drv(1, 1, 1, 1, 0, 20'h12345, 1); step("inta_ale", 1, 0, 20'h12345, 0);
    drv(0, 1, 1, 0, 0, 20'h0, 0);     step("inta_w1",  0, 5, 20'h12345, 0);
                                      step("inta_w2",  0, 5, 20'h12345, 0);
                                      step("inta_w3",  0, 5, 20'h12345, 0);
                                      step("inta_w4",  0, 5, 20'h12345, 0);
                                      step("inta_w5",  0, 5, 20'h12345, 0);
    drv(0, 1, 1, 0, 0, 20'h0, 1);     step("inta_done",1, 5, 20'h12345, 0);
    drv(0, 1, 1, 1, 0, 20'h0, 1);     step("inta_end", 1, 0, 20'h12345, 0);

    // Strobe priority, ALE during DONE, strobes released during WAIT
    drv(1, 1, 1, 1, 0, 20'hABCDE, 1); step("prio_ale",      1, 0, 20'hABCDE, 0);
    drv(0, 0, 0, 1, 0, 20'h0, 1);     step("prio_wr_rd",    1, 2, 20'hABCDE, 0);
    drv(1, 0, 0, 1, 0, 20'h55555, 1); step("ale_in_done",   1, 0, 20'h55555, 0);
    drv(0, 0, 0, 0, 1, 20'h0, 1);     step("prio_inta",     0, 5, 20'h55555, 0);
    drv(0, 1, 1, 1, 1, 20'h0, 1);     step("release_wait",  1, 0, 20'h55555, 0);

    // ALE during WAIT aborts the cycle
    drv(1, 1, 1, 1, 1, 20'h00070, 1); step("abort_ale",   1, 0, 20'h00070, 0);
    drv(0, 0, 1, 1, 1, 20'h0, 1);     step("abort_w1",    0, 3, 20'h00070, 0);
                                      step("abort_w2",    0, 3, 20'h00070, 0);
    drv(1, 0, 1, 1, 1, 20'h00080, 1); step("abort_relat", 1, 0, 20'h00080, 0);
    drv(0, 0, 1, 1, 1, 20'h0, 1);     step("abort_w_new", 0, 3, 20'h00080, 0);
    drv(0, 1, 1, 1, 1, 20'h0, 1);     step("abort_end",   1, 0, 20'h00080, 0);

    // Asynchronous reset during WAIT, checked before any further rising edge
    drv(1, 1, 1, 1, 1, 20'h11111, 1); step("rst_ale",  1, 0, 20'h11111, 0);
    drv(0, 1, 0, 1, 1, 20'h0, 1);     step("rst_wait", 0, 4, 20'h11111, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_toaddr = '0;
    step("rst_async", 1, 0, 20'h0, 0);
    rst_n = 1'b1;
    step("rst_no_ale", 1, 0, 20'h0, 0);
    drv(1, 1, 1, 1, 1, 20'h22222, 1); step("post_rst_ale", 1, 0, 20'h22222, 0);
    drv(0, 1, 0, 1, 1, 20'h0, 1);     step("post_rst_w1",  0, 4, 20'h22222, 0);
                                      step("post_rst_w2",  0, 4, 20'h22222, 0);
                                      step("post_rst_w3",  0, 4, 20'h22222, 0);
                                      step("post_rst_done",1, 4, 20'h22222, 0);
    drv(0, 1, 1, 1, 1, 20'h0, 1);     step("post_rst_end", 1, 0, 20'h22222, 0);

    // EXT_RDY stuck low on an I/O read
    drv(1, 1, 1, 1, 1, 20'h003F8, 1); step("stuck_ale", 1, 0, 20'h003F8, 0);
    drv(0, 0, 1, 1, 1, 20'h0, 0);     step("stuck_w0",  0, 3, 20'h003F8, 0);
`ifdef BUS_TIMEOUT_EN
    for (int i = 1; i <= 7; i++) step("stuck_wait", 0, 3, 20'h003F8, 0);
    exp_toaddr = 20'h003F8;
    step("timeout_fire", 1, 3, 20'h003F8, 1);
    step("timeout_once", 1, 3, 20'h003F8, 0);
    drv(0, 1, 1, 1, 1, 20'h0, 0);
    step("timeout_end", 1, 0, 20'h003F8, 0);
`else
    for (int i = 1; i <= 12; i++) step("stuck_wait", 0, 3, 20'h003F8, 0);
    drv(0, 0, 1, 1, 1, 20'h0, 1);
    step("stuck_done", 1, 3, 20'h003F8, 0);
    drv(0, 1, 1, 1, 1, 20'h0, 1);
    step("stuck_end", 1, 0, 20'h003F8, 0);
`endif

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected records left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_wait_gen.md
BUS_WAIT_GEN -- requirements
Module: bus_wait_gen

Interface
REQ-001 SHALL provide parameter MEM_WAIT, default 0: wait cycles (0-15) inserted in memory read/write cycles.
REQ-002 SHALL provide parameter IO_WAIT, default 1: wait cycles (0-15) inserted in I/O read/write cycles.
REQ-003 SHALL provide parameter INTA_WAIT, default 1: wait cycles (0-15) inserted in interrupt-acknowledge cycles.
REQ-004 SHALL provide parameter TIMEOUT_CYCLES, default 255: WAIT-state cycle limit (1-255) before forced completion.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, with ports CORE_CLK and RESET_n.
REQ-006 CORE_CLK  input  1  sole clock; every register samples on its rising edge.
REQ-007 RESET_n  input  1  asynchronous active-low reset.
REQ-008 ALE  input  1  address latch enable from the 8088 core.
REQ-009 RD_n, WR_n, INTA_n  input  1 each  active-low bus strobes from the 8088 core.
REQ-010 IOM  input  1  1 = I/O cycle, 0 = memory cycle.
REQ-011 ADDR  input  20  bus address, valid while ALE=1.
REQ-012 EXT_RDY  input  1  device ready; 0 extends the cycle.
REQ-013 READY  output  1  registered; drives the 8088 core READY input.
REQ-014 BUS_CYCLE  output  3  0 idle, 1 mem rd, 2 mem wr, 3 io rd, 4 io wr, 5 inta.
REQ-015 CYC_ADDR  output  20  address latched for the current cycle.
REQ-016 TIMEOUT  output  1  one-cycle pulse on forced completion.
REQ-017 TIMEOUT_ADDR  output  20  CYC_ADDR of the most recent timed-out cycle.

Function
REQ-018 The FSM SHALL have states IDLE, ADDR, WAIT and DONE.
REQ-019 IDLE->ADDR: on a cycle with ALE=1, latching ADDR into CYC_ADDR.
REQ-020 ADDR->WAIT: on the first edge after ALE falls at which RD_n, WR_n or INTA_n is sampled 0; BUS_CYCLE is set from the strobe and IOM, and the 4-bit counter is loaded with the wait count for that cycle type.
REQ-021 Strobe priority when several are low together: INTA_n, then WR_n, then RD_n.
REQ-022 Wait count 0: ADDR SHALL go directly to DONE and READY SHALL stay 1.
REQ-023 In WAIT, the counter SHALL decrement by 1 per cycle, saturating at 0.
REQ-024 In WAIT, READY SHALL be 0 while counter != 0 or EXT_RDY = 0.
REQ-025 WAIT->DONE: when counter = 0 and EXT_RDY = 1; READY = 1 from that edge.
REQ-026 With EXT_RDY held 1, READY SHALL be 0 for exactly W consecutive cycles (W = loaded count), starting the cycle after the strobe is sampled low.
REQ-027 DONE->IDLE: when all strobes are sampled high; BUS_CYCLE returns to 0 on the same edge.
REQ-028 ALE=1 in any non-IDLE state SHALL abort the current cycle, set READY=1, relatch CYC_ADDR and enter ADDR.
REQ-029 Strobes deasserting during WAIT SHALL force IDLE with READY=1, with no TIMEOUT pulse.
REQ-030 READY SHALL be 1 in IDLE, ADDR and DONE.

Reset
REQ-031 RESET_n=0 SHALL asynchronously force: state IDLE, READY=1, BUS_CYCLE=0, CYC_ADDR=0, counter=0, TIMEOUT=0, TIMEOUT_ADDR=0, timeout counter=0.
REQ-032 Reset asserted mid-cycle SHALL abandon the cycle; after release the block SHALL wait for the next ALE.

Configuration
REQ-033 Macro BUS_TIMEOUT_EN defined: an 8-bit counter SHALL count WAIT cycles and clear on entry to WAIT.
REQ-034 With BUS_TIMEOUT_EN, reaching TIMEOUT_CYCLES SHALL force WAIT->DONE, set READY=1, pulse TIMEOUT for one cycle and load TIMEOUT_ADDR from CYC_ADDR.
REQ-035 Macro BUS_TIMEOUT_EN undefined: no timeout logic; TIMEOUT and TIMEOUT_ADDR SHALL be constant 0 and WAIT SHALL persist until EXT_RDY=1.

Verification
REQ-036 Mem read at 0xF0000, MEM_WAIT=0, EXT_RDY=1 -> READY stays 1; BUS_CYCLE=1; CYC_ADDR=0xF0000.
REQ-037 I/O write at 0x00060, IO_WAIT=3, EXT_RDY=1 -> READY low exactly 3 cycles; BUS_CYCLE=4.
REQ-038 INTA cycle, INTA_WAIT=1, EXT_RDY low 5 cycles -> READY low until the cycle after EXT_RDY rises; BUS_CYCLE=5.
REQ-039 With BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, EXT_RDY stuck 0 on I/O read at 0x003F8 -> after 8 WAIT cycles READY=1, TIMEOUT pulses once, TIMEOUT_ADDR=0x003F8.
REQ-040 RESET_n pulsed low during WAIT -> READY=1 and BUS_CYCLE=0 immediately; the next ALE starts a clean cycle.
REQ-041 New ALE during DONE -> ADDR relatched, state ADDR, READY=1.
